// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bus layout,
// stall patterns, FSM state encodings and the register-match helper.
package pipe_ctrl_pkg;

    localparam int STALL_PC   = 0;
    localparam int STALL_IFID = 1;
    localparam int STALL_IDEX = 2;
    localparam int STALL_BACK = 3;

    typedef logic [3:0] stall_bus_t;

    localparam stall_bus_t STALL_NONE  = 4'b0000;
    localparam stall_bus_t STALL_FETCH = stall_bus_t'(1 << STALL_PC);
    localparam stall_bus_t STALL_LUSE  = stall_bus_t'((1 << STALL_PC) | (1 << STALL_IFID));
    localparam stall_bus_t STALL_ALL   = stall_bus_t'((1 << STALL_PC) | (1 << STALL_IFID) |
                                                      (1 << STALL_IDEX) | (1 << STALL_BACK));

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    // A source operand depends on rd only if the instruction actually reads it.
    function automatic logic reg_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_ctrl_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage core: hazard priority logic, debug
// halt/drain FSM, memory-wait timeout and saturating performance counters.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 4,
    parameter int WAIT_MAX  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_r1_i,
    input  logic [4:0]       id_r2_i,
    input  logic             id_r1_used_i,
    input  logic             id_r2_used_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             idex_mem_re_i,
    input  logic             ex_br_en_i,
    input  logic             exmem_mem_re_i,
    input  logic             exmem_mem_wr_i,
    input  logic             dmem_ready_i,
    input  logic             imem_ready_i,
    input  logic             halt_req_i,
    output logic [3:0]       stall_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             pc_br_en_o,
    output logic             halt_ack_o,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int DRN_W  = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam int WAIT_W = $clog2(WAIT_MAX) + 1;

    state_e              state;
    logic [DRN_W-1:0]    drain_cnt;
    logic                halt_ack_q;
    logic                err_q;
    logic [WAIT_W-1:0]   wait_cnt;

    logic       dwait, luse, iwait, halted;
    stall_bus_t stall_bus;
    logic       flush_ifid, flush_idex, br_en;
    logic       wait_inc, wait_at_max;

    assign dwait  = (exmem_mem_re_i | exmem_mem_wr_i) & ~dmem_ready_i;
    assign luse   = idex_mem_re_i && (idex_rd_i != 5'd0) &&
                    (reg_hit(id_r1_used_i, id_r1_i, idex_rd_i) ||
                     reg_hit(id_r2_used_i, id_r2_i, idex_rd_i));
    assign iwait  = ~imem_ready_i;
    assign halted = (state == ST_HALTED);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stall_bus  = STALL_NONE;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        br_en      = 1'b0;
        if (halted || dwait) begin
            // A taken branch waits in EX until the memory access completes.
            stall_bus = STALL_ALL;
        end else if (ex_br_en_i) begin
            br_en      = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (luse) begin
            stall_bus  = STALL_LUSE;
            flush_idex = 1'b1;
        end else if ((state == ST_DRAIN) || iwait) begin
            stall_bus  = STALL_FETCH;
            flush_ifid = 1'b1;
        end
    end

    // Halt/drain FSM; halt_ack is registered so it tracks the HALTED state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            drain_cnt  <= '0;
            halt_ack_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req_i) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRN_W'(DRAIN_CYC);
                    end
                end
                ST_DRAIN: begin
                    if (!halt_req_i) begin
                        state <= ST_RUN;
                    end else if ((drain_cnt == '0) || ((drain_cnt == DRN_W'(1)) && !dwait)) begin
                        state      <= ST_HALTED;
                        drain_cnt  <= '0;
                        halt_ack_q <= 1'b1;
                    end else if (!dwait) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt_req_i) begin
                        state      <= ST_RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    halt_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign wait_inc    = (dwait | iwait) & ~halted;
    assign wait_at_max = (wait_cnt == WAIT_W'(WAIT_MAX - 1));

    pipe_ctrl_sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wait_inc),
        .clr (~wait_inc),
        .q   (wait_cnt)
    );

    pipe_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((stall_bus != STALL_NONE) && !halted),
        .clr (1'b0),
        .q   (stall_cnt_o)
    );

    pipe_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br_en),
        .clr (1'b0),
        .q   (flush_cnt_o)
    );

    // Sticky timeout flag; the combinational term makes it visible on the limit cycle itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (wait_at_max) begin
            err_q <= 1'b1;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign stall_o       = rst ? stall_bus  : STALL_NONE;
    assign flush_if_id_o = rst & flush_ifid;
    assign flush_id_ex_o = rst & flush_idex;
    assign pc_br_en_o    = rst & br_en;
    assign halt_ack_o    = halt_ack_q;
    assign err_timeout_o = rst & (err_q | wait_at_max);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected output vectors are queued when stimulus
// is applied and compared at the following falling edge.
module tb_pipe_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       id_r1_i, id_r2_i, idex_rd_i;
    logic             id_r1_used_i, id_r2_used_i, idex_mem_re_i, ex_br_en_i;
    logic             exmem_mem_re_i, exmem_mem_wr_i, dmem_ready_i, imem_ready_i, halt_req_i;
    logic [3:0]       stall_o;
    logic             flush_if_id_o, flush_id_ex_o, pc_br_en_o, halt_ack_o, err_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(4), .WAIT_MAX(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_r1_i        (id_r1_i),
        .id_r2_i        (id_r2_i),
        .id_r1_used_i   (id_r1_used_i),
        .id_r2_used_i   (id_r2_used_i),
        .idex_rd_i      (idex_rd_i),
        .idex_mem_re_i  (idex_mem_re_i),
        .ex_br_en_i     (ex_br_en_i),
        .exmem_mem_re_i (exmem_mem_re_i),
        .exmem_mem_wr_i (exmem_mem_wr_i),
        .dmem_ready_i   (dmem_ready_i),
        .imem_ready_i   (imem_ready_i),
        .halt_req_i     (halt_req_i),
        .stall_o        (stall_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .pc_br_en_o     (pc_br_en_o),
        .halt_ack_o     (halt_ack_o),
        .err_timeout_o  (err_timeout_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    // {stall, flush_if_id, flush_id_ex, pc_br_en, halt_ack, err_timeout}
    typedef struct packed {
        logic [3:0] stall;
        logic       fifd;
        logic       fidex;
        logic       br;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t             sb[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] m_stall_cnt = '0;
    logic [CNT_W-1:0] m_flush_cnt = '0;
    logic             exp_err = 1'b0;

    // fl = {flush_if_id, flush_id_ex, pc_br_en}
    function automatic exp_t mk(input logic [3:0] s, input logic [2:0] fl, input logic ack);
        exp_t e;
        e.stall = s;
        e.fifd  = fl[2];
        e.fidex = fl[1];
        e.br    = fl[0];
        e.ack   = ack;
        e.err   = exp_err;
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [CNT_W-1:0] o, input logic [CNT_W-1:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        exp_t o;
        e = sb.pop_front();
        o = {stall_o, flush_if_id_o, flush_id_ex_o, pc_br_en_o, halt_ack_o, err_timeout_o};
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed stall/fifd/fidex/br/ack/err=%b expected %b", tag, o, e);
        end
        check_val({tag, "/stall_cnt"}, stall_cnt_o, m_stall_cnt);
        check_val({tag, "/flush_cnt"}, flush_cnt_o, m_flush_cnt);
    endtask

    // One clock cycle: inputs are already applied; check at negedge, then advance.
    task automatic cycle(input string tag, input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        check_out(tag);
        if ((e.stall != 4'b0000) && !e.ack) m_stall_cnt += 1;
        if (e.br) m_flush_cnt += 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_r1_i        = 5'd0;
        id_r2_i        = 5'd0;
        id_r1_used_i   = 1'b0;
        id_r2_used_i   = 1'b0;
        idex_rd_i      = 5'd0;
        idex_mem_re_i  = 1'b0;
        ex_br_en_i     = 1'b0;
        exmem_mem_re_i = 1'b0;
        exmem_mem_wr_i = 1'b0;
        dmem_ready_i   = 1'b1;
        imem_ready_i   = 1'b1;
        halt_req_i     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        imem_ready_i = 1'b0;
        #2;
        sb.push_back(mk(4'b0000, 3'b000, 1'b0));
        check_out("reset");
        @(negedge clk);
        rst = 1'b1;
        imem_ready_i = 1'b1;
        @(posedge clk);
        #1;

        cycle("idle", mk(4'b0000, 3'b000, 1'b0));

        // Load-use on rs1: one bubble, then the hazard is gone.
        idex_mem_re_i = 1'b1; idex_rd_i = 5'd5; id_r1_i = 5'd5; id_r1_used_i = 1'b1;
        cycle("luse_rs1", mk(4'b0011, 3'b010, 1'b0));
        idex_mem_re_i = 1'b0;
        cycle("luse_clear", mk(4'b0000, 3'b000, 1'b0));

        // A load to x0 never creates a dependency.
        idex_mem_re_i = 1'b1; idex_rd_i = 5'd0; id_r1_i = 5'd0;
        cycle("luse_x0", mk(4'b0000, 3'b000, 1'b0));

        // rs2 match counts only when rs2 is read.
        idle_inputs();
        idex_mem_re_i = 1'b1; idex_rd_i = 5'd7; id_r2_i = 5'd7; id_r2_used_i = 1'b1;
        cycle("luse_rs2", mk(4'b0011, 3'b010, 1'b0));
        id_r2_used_i = 1'b0;
        cycle("luse_rs2_unused", mk(4'b0000, 3'b000, 1'b0));

        // Load-use outranks an instruction-fetch wait.
        id_r2_used_i = 1'b1; imem_ready_i = 1'b0;
        cycle("luse_over_iwait", mk(4'b0011, 3'b010, 1'b0));
        idle_inputs();
        imem_ready_i = 1'b0;
        cycle("iwait", mk(4'b0001, 3'b100, 1'b0));

        // Taken branch overrides the fetch-wait pc hold.
        ex_br_en_i = 1'b1;
        cycle("branch_iwait", mk(4'b0000, 3'b111, 1'b0));
        idle_inputs();
        cycle("after_branch", mk(4'b0000, 3'b000, 1'b0));

        // Data-memory wait holds a branch in EX for 3 cycles, then releases it.
        exmem_mem_re_i = 1'b1; dmem_ready_i = 1'b0; ex_br_en_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle("dwait_branch", mk(4'b1111, 3'b000, 1'b0));
        dmem_ready_i = 1'b1;
        cycle("dwait_release", mk(4'b0000, 3'b111, 1'b0));
        idle_inputs();
        exmem_mem_wr_i = 1'b1; dmem_ready_i = 1'b0;
        cycle("dwait_store", mk(4'b1111, 3'b000, 1'b0));
        idle_inputs();
        cycle("idle2", mk(4'b0000, 3'b000, 1'b0));

        // Debug halt: transition cycle, 4 drain cycles, then HALTED.
        halt_req_i = 1'b1;
        cycle("halt_run", mk(4'b0000, 3'b000, 1'b0));
        for (int i = 0; i < 4; i++) cycle("drain", mk(4'b0001, 3'b100, 1'b0));
        cycle("halted", mk(4'b1111, 3'b000, 1'b1));
        ex_br_en_i = 1'b1;
        cycle("halted_branch", mk(4'b1111, 3'b000, 1'b1));
        ex_br_en_i = 1'b0;
        halt_req_i = 1'b0;
        cycle("halted_release", mk(4'b1111, 3'b000, 1'b1));
        cycle("resume_run", mk(4'b0000, 3'b000, 1'b0));

        // Fetch wait for 70 cycles: timeout flag rises on cycle 64 and sticks.
        imem_ready_i = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            exp_err = (k >= 64);
            cycle("iwait_timeout", mk(4'b0001, 3'b100, 1'b0));
        end
        imem_ready_i = 1'b1;
        cycle("timeout_sticky", mk(4'b0000, 3'b000, 1'b0));

        // Branch during drain redirects the pc; reset mid-drain clears everything.
        halt_req_i = 1'b1;
        cycle("halt2_run", mk(4'b0000, 3'b000, 1'b0));
        cycle("drain2", mk(4'b0001, 3'b100, 1'b0));
        ex_br_en_i = 1'b1;
        cycle("drain_branch", mk(4'b0000, 3'b111, 1'b0));
        ex_br_en_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        m_stall_cnt = '0;
        m_flush_cnt = '0;
        exp_err     = 1'b0;
        sb.push_back(mk(4'b0000, 3'b000, 1'b0));
        check_out("reset_mid_drain");
        @(negedge clk);
        rst = 1'b1;
        halt_req_i = 1'b0;
        @(posedge clk);
        #1;
        cycle("run_after_reset", mk(4'b0000, 3'b000, 1'b0));
        imem_ready_i = 1'b0;
        cycle("iwait_after_reset", mk(4'b0001, 3'b100, 1'b0));
        idle_inputs();
        cycle("final_idle", mk(4'b0000, 3'b000, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
